// File: rtl/r2sdf_reorder_pkg.sv
// R2SdfDefinesPkg: shared types and helpers for the R2SDF FFT pipeline.
//   Cplx      : 16-bit signed real/imaginary sample pair
//   CPLX_W    : packed width of one Cplx sample
//   rd_state_e: read-side state of the output reorder buffer
//   bitrev()  : reverses the low 'w' bits of a value (w <= 16)
package R2SdfDefinesPkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } Cplx;

    localparam int CPLX_W = $bits(Cplx);

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_e;

    // Bit i of v lands on bit w-1-i; bits at and above w come back as zero,
    // so callers cast the result down to their own address width.
    function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < w) begin
                r[w - 1 - i] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/r2sdf_reorder_if.sv
// r2sdf_reorder_if: sample stream into and out of the reorder buffer.
//   en        : clock enable for the whole stream
//   in        : bit-reversed-order input sample
//   in_sync   : marks the last input sample of a frame
//   out       : natural-order output sample
//   out_valid : out carries a sample of a completed frame
//   out_sync  : marks natural index LEN-1 of an output frame
// master = upstream source (and output consumer), slave = reorder block.
interface r2sdf_reorder_if;

    logic                   en;
    R2SdfDefinesPkg::Cplx   in;
    logic                   in_sync;
    R2SdfDefinesPkg::Cplx   out;
    logic                   out_valid;
    logic                   out_sync;

    modport master (
        output en, in, in_sync,
        input  out, out_valid, out_sync
    );

    modport slave (
        input  en, in, in_sync,
        output out, out_valid, out_sync
    );

endinterface

// File: rtl/r2sdf_reorder_sp_ram_rf.sv
// SpRamRf: single-port register-file RAM with a registered read port.
//   clk   : clock
//   ce    : access enable; no write and no read-data update when low
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access, held otherwise
// Contents and rdata are not reset.
module SpRamRf #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/r2sdf_reorder.sv
// r2sdf_reorder: converts bit-reversed FFT output frames to natural order.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : r2sdf_reorder_if.slave (en, in, in_sync -> out, out_valid, out_sync)
// Two ping-pong banks: the write bank is filled at bitrev(wcnt); when a frame
// ends aligned (in_sync with wcnt = LEN-1) the banks swap and the filled bank
// is read out in natural order. Output latency is RAM read + output register.
module r2sdf_reorder
    import R2SdfDefinesPkg::*;
#(
    parameter int STG = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    r2sdf_reorder_if.slave   bus
);

    logic [STG-1:0]     wcnt;
    logic [STG-1:0]     rcnt;
    logic [STG-1:0]     wr_addr;
    logic               wsel;
    rd_state_e          rd_state;
    rd_state_e          rd_next;
    logic               en;
    logic               aligned_end;
    logic               rd_fire;
    logic               rd_v;
    logic               rd_last;
    logic               rd_bank;
    logic               ce0, ce1, we0, we1;
    logic [STG-1:0]     addr0, addr1;
    logic [CPLX_W-1:0]  rdata0, rdata1;
    Cplx                out_q;
    logic               out_valid_q;
    logic               out_sync_q;

    assign en          = bus.en;
    assign aligned_end = en & bus.in_sync & (&wcnt);
    assign rd_fire     = en & (rd_state == RD_ACTIVE);
    assign wr_addr     = STG'(bitrev(16'(wcnt), STG));

    // wsel = 0 means bank 0 is being written and bank 1 read, and vice versa.
    assign ce0   = wsel ? rd_fire : en;
    assign we0   = ~wsel;
    assign addr0 = wsel ? rcnt : wr_addr;
    assign ce1   = wsel ? en : rd_fire;
    assign we1   = wsel;
    assign addr1 = wsel ? wr_addr : rcnt;

    SpRamRf #(.DW(CPLX_W), .AW(STG)) u_bank0 (
        .clk   (clk),
        .ce    (ce0),
        .we    (we0),
        .addr  (addr0),
        .wdata (bus.in),
        .rdata (rdata0)
    );

    SpRamRf #(.DW(CPLX_W), .AW(STG)) u_bank1 (
        .clk   (clk),
        .ce    (ce1),
        .we    (we1),
        .addr  (addr1),
        .wdata (bus.in),
        .rdata (rdata1)
    );

    // Write side: any in_sync restarts the frame; only an aligned one swaps
    // banks, so partial frames are silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            wsel <= 1'b0;
        end else if (en) begin
            if (bus.in_sync) begin
                wcnt <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
            if (aligned_end) begin
                wsel <= ~wsel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    // A new aligned frame end takes priority over finishing the current read,
    // which is what keeps back-to-back frames gapless.
    always_comb begin
        rd_next = rd_state;
        if (en) begin
            if (aligned_end) begin
                rd_next = RD_ACTIVE;
            end else if ((rd_state == RD_ACTIVE) && (&rcnt)) begin
                rd_next = RD_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
        end else if (en) begin
            if (aligned_end) begin
                rcnt <= '0;
            end else if (rd_fire) begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    // rd_bank remembers which bank was read, because wsel may flip on the
    // same edge as the last read of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v    <= 1'b0;
            rd_last <= 1'b0;
            rd_bank <= 1'b0;
        end else if (en) begin
            rd_v    <= rd_fire;
            rd_last <= &rcnt;
            rd_bank <= ~wsel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sync_q  <= 1'b0;
        end else if (en) begin
            out_valid_q <= rd_v;
            out_sync_q  <= rd_v & rd_last;
            if (rd_v) begin
                out_q <= rd_bank ? rdata1 : rdata0;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sync  = out_sync_q;

endmodule

// File: tb/tb_r2sdf_reorder.sv
// tb_r2sdf_reorder: self-checking bench for r2sdf_reorder (STG = 4).
// A frame-level model schedules every natural-order output sample against a
// count of enabled clock edges; a compare process checks the DUT each cycle.
module tb_r2sdf_reorder;
    import R2SdfDefinesPkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    r2sdf_reorder_if bus ();

    r2sdf_reorder #(.STG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               sync;
    } exp_t;

    typedef struct {
        int                 t;
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               sync;
    } cap_t;

    int                 tests = 0;
    int                 fails = 0;
    int                 encount = 0;
    int                 mwcnt = 0;
    logic signed [15:0] mbuf_re [16];
    logic signed [15:0] mbuf_im [16];
    exp_t               exp_map [int];
    logic signed [15:0] last_re = 0;
    logic signed [15:0] last_im = 0;
    cap_t               cap [$];
    int                 last_seen = -1;

    function automatic int brev4(input int k);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if ((k >> i) % 2 == 1) r += 1 << (3 - i);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock edge of stimulus; the model sees the edge only if it is an
    // input cycle. The k-th sample of a frame belongs to natural bin brev(k).
    task automatic applyStimulus(input logic e, input logic signed [15:0] re,
                                 input logic signed [15:0] im, input logic s);
        int a;
        bus.en      = e;
        bus.in.re   = re;
        bus.in.im   = im;
        bus.in_sync = s;
        @(posedge clk);
        if (rst_n && e) begin
            encount++;
            a = brev4(mwcnt);
            mbuf_re[a] = re;
            mbuf_im[a] = im;
            if (s) begin
                if (mwcnt == 15) begin
                    for (int n = 0; n < 16; n++) begin
                        exp_map[encount + 2 + n] = '{mbuf_re[n], mbuf_im[n], n == 15};
                    end
                end
                mwcnt = 0;
            end else begin
                mwcnt = (mwcnt + 1) % 16;
            end
        end
        #1;
    endtask

    task automatic sendSample(input logic signed [15:0] re, input logic signed [15:0] im,
                              input logic s, input int enprob);
        while ($urandom_range(99) >= enprob) begin
            applyStimulus(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        applyStimulus(1'b1, re, im, s);
    endtask

    task automatic sendFrame(input int offset, input int enprob);
        for (int k = 0; k < 16; k++) begin
            sendSample(16'(brev4(k) + offset), 16'(-brev4(k)), k == 15, enprob);
        end
    endtask

    task automatic sendRandomFrame(input int enprob);
        for (int k = 0; k < 16; k++) begin
            sendSample(16'($urandom), 16'($urandom), k == 15, enprob);
        end
    endtask

    task automatic flush(input int n, input int enprob);
        for (int i = 0; i < n; i++) begin
            sendSample(16'($urandom), 16'($urandom), 1'b0, enprob);
        end
    endtask

    // Captured frames must be consecutive ramps: frame f has re = base+f*step+n.
    task automatic checkRamp(input int count, input int base, input int step);
        checkOutput("cap_count", cap.size(), count);
        for (int i = 0; i < count; i++) begin
            if (i < cap.size()) begin
                checkOutput("ramp_re", cap[i].re, base + (i / 16) * step + (i % 16));
                checkOutput("ramp_im", cap[i].im, -(i % 16));
                checkOutput("ramp_sync", int'(cap[i].sync), int'(i % 16 == 15));
                checkOutput("ramp_gapless", cap[i].t, cap[0].t + i);
            end
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        exp_map.delete();
        mwcnt   = 0;
        last_re = 0;
        last_im = 0;
        #1;
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_out_sync", int'(bus.out_sync), 0);
        checkOutput("rst_out_re", bus.out.re, 0);
        checkOutput("rst_out_im", bus.out.im, 0);
        bus.en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Compare process: output state is a function of the enabled-edge count.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (exp_map.exists(encount)) begin
                e = exp_map[encount];
                checkOutput("out_valid", int'(bus.out_valid), 1);
                checkOutput("out_re", bus.out.re, e.re);
                checkOutput("out_im", bus.out.im, e.im);
                checkOutput("out_sync", int'(bus.out_sync), int'(e.sync));
                last_re = e.re;
                last_im = e.im;
                if (encount != last_seen) begin
                    cap.push_back('{encount, bus.out.re, bus.out.im, bus.out_sync});
                end
                last_seen = encount;
            end else begin
                checkOutput("idle_valid", int'(bus.out_valid), 0);
                checkOutput("idle_sync", int'(bus.out_sync), 0);
                checkOutput("idle_hold_re", bus.out.re, last_re);
                checkOutput("idle_hold_im", bus.out.im, last_im);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.in      = '0;
        bus.in_sync = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("init_valid", int'(bus.out_valid), 0);
        checkOutput("init_sync", int'(bus.out_sync), 0);
        checkOutput("init_re", bus.out.re, 0);

        // Single frame: ramp out, index 0 two cycles after in_sync.
        cap.delete();
        sendFrame(0, 100);
        applyStimulus(1'b1, 16'sd7, 16'sd7, 1'b0);
        checkOutput("lat1_valid", int'(bus.out_valid), 0);
        applyStimulus(1'b1, 16'sd7, 16'sd7, 1'b0);
        checkOutput("lat2_valid", int'(bus.out_valid), 1);
        checkOutput("lat2_re", bus.out.re, 0);
        checkOutput("lat2_im", bus.out.im, 0);
        flush(30, 100);
        checkRamp(16, 0, 0);

        // Three back-to-back frames.
        cap.delete();
        sendFrame(0, 100);
        sendFrame(100, 100);
        sendFrame(200, 100);
        flush(32, 100);
        checkRamp(48, 0, 100);

        // Misaligned sync at wcnt = 7, then an aligned frame.
        cap.delete();
        for (int k = 0; k < 8; k++) begin
            sendSample(16'(77 + k), 16'(5), k == 7, 100);
        end
        sendFrame(0, 100);
        flush(32, 100);
        checkRamp(16, 0, 0);

        // Randomly gated enable on write and read.
        cap.delete();
        sendFrame(0, 50);
        flush(32, 50);
        checkRamp(16, 0, 0);

        // Reset while out index 5 is presented.
        cap.delete();
        sendFrame(0, 100);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 16'sd3, 16'sd3, 1'b0);
        end
        checkOutput("pre_rst_valid", int'(bus.out_valid), 1);
        checkOutput("pre_rst_re", bus.out.re, 5);
        doReset();
        cap.delete();
        sendFrame(300, 100);
        flush(32, 100);
        checkRamp(16, 300, 0);

        // Random mix of aligned frames, partial frames and wrapped frames.
        for (int it = 0; it < 30; it++) begin
            int choice;
            int len;
            int prob;
            choice = $urandom_range(2);
            prob   = ($urandom_range(1) == 1) ? 100 : 70;
            if (choice == 0) begin
                sendRandomFrame(prob);
            end else if (choice == 1) begin
                len = $urandom_range(15, 1);
                for (int k = 0; k < len; k++) begin
                    sendSample(16'($urandom), 16'($urandom), k == len - 1, prob);
                end
            end else begin
                flush(16, prob);
            end
        end
        flush(32, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
